// File: rtl/down_timer.sv
// down_timer: MM:SS BCD countdown timer (kitchen-timer mode).
// Loads a clamped preset, decrements one second per en strobe while running,
// and raises alarm on reaching 00:00.
// Optional feature macro: TIMER_AUTORELOAD_EN -- on expiry the digits reload
// from the last accepted preset, counting continues and alarm is a 1-clk pulse.
module down_timer #(
  parameter int unsigned MAX_MIN    = 59,
  parameter int unsigned DONE_TICKS = 10
) (
  input  logic       clk,
  input  logic       res,
  input  logic       en,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] set_mt,
  input  logic [3:0] set_mu,
  input  logic [3:0] set_st,
  input  logic [3:0] set_su,
  output logic [3:0] mt,
  output logic [3:0] mu,
  output logic [3:0] st,
  output logic [3:0] su,
  output logic       bw,
  output logic       running,
  output logic       alarm,
  output logic       zero
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  localparam logic [3:0] MAX_MT    = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MU    = 4'(MAX_MIN % 10);
  localparam logic [7:0] LAST_TICK = 8'(DONE_TICKS - 1);

  state_t     state;
  logic [7:0] tick_cnt;

  logic [3:0] c_mt, c_mu, c_st, c_su;
  logic [3:0] d_mt, d_mu, d_st, d_su;
  logic       b0, b1, b2, b3;
  logic       last;

`ifdef TIMER_AUTORELOAD_EN
  logic [3:0] r_mt, r_mu, r_st, r_su;
`endif

  assign zero = (mt == 4'd0) && (mu == 4'd0) && (st == 4'd0) && (su == 4'd0);

  // Preset clamping: per-digit range first, then the whole minutes value.
  always_comb begin
    c_su = (set_su > 4'd9) ? 4'd9 : set_su;
    c_st = (set_st > 4'd5) ? 4'd5 : set_st;
    c_mu = (set_mu > 4'd9) ? 4'd9 : set_mu;
    c_mt = (set_mt > 4'd9) ? 4'd9 : set_mt;
    // Valid BCD digit pairs order the same as their binary concatenation.
    if ({c_mt, c_mu} > {MAX_MT, MAX_MU}) begin
      c_mt = MAX_MT;
      c_mu = MAX_MU;
    end
  end

  // One-second decrement with borrow ripple su -> st -> mu -> mt.
  always_comb begin
    b0   = (su == 4'd0);
    d_su = b0 ? 4'd9 : su - 4'd1;
    b1   = b0 && (st == 4'd0);
    d_st = b0 ? ((st == 4'd0) ? 4'd5 : st - 4'd1) : st;
    b2   = b1 && (mu == 4'd0);
    d_mu = b1 ? ((mu == 4'd0) ? 4'd9 : mu - 4'd1) : mu;
    b3   = b2 && (mt == 4'd0);
    d_mt = b2 ? ((mt == 4'd0) ? 4'd9 : mt - 4'd1) : mt;
    last = (mt == 4'd0) && (mu == 4'd0) && (st == 4'd0) && (su == 4'd1);
  end

  // Control FSM with digit registers and registered status outputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= IDLE;
      mt       <= '0;
      mu       <= '0;
      st       <= '0;
      su       <= '0;
      bw       <= 1'b0;
      running  <= 1'b0;
      alarm    <= 1'b0;
      tick_cnt <= '0;
`ifdef TIMER_AUTORELOAD_EN
      r_mt     <= '0;
      r_mu     <= '0;
      r_st     <= '0;
      r_su     <= '0;
`endif
    end else begin
      bw <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      alarm <= 1'b0;
`endif
      if (load && state != RUN) begin
        mt <= c_mt;
        mu <= c_mu;
        st <= c_st;
        su <= c_su;
`ifdef TIMER_AUTORELOAD_EN
        r_mt <= c_mt;
        r_mu <= c_mu;
        r_st <= c_st;
        r_su <= c_su;
`endif
        if (state == ALARM) begin
          state <= IDLE;
          alarm <= 1'b0;
        end
      end else begin
        case (state)
          IDLE, PAUSE: begin
            if (!stop && start && !zero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (en) begin
              bw <= b3;
              if (last) begin
`ifdef TIMER_AUTORELOAD_EN
                mt    <= r_mt;
                mu    <= r_mu;
                st    <= r_st;
                su    <= r_su;
                alarm <= 1'b1;
`else
                mt       <= d_mt;
                mu       <= d_mu;
                st       <= d_st;
                su       <= d_su;
                state    <= ALARM;
                running  <= 1'b0;
                alarm    <= 1'b1;
                tick_cnt <= '0;
`endif
              end else begin
                mt <= d_mt;
                mu <= d_mu;
                st <= d_st;
                su <= d_su;
              end
            end
          end
          ALARM: begin
            if (stop) begin
              state <= IDLE;
              alarm <= 1'b0;
            end else if (en) begin
              if (tick_cnt == LAST_TICK) begin
                state    <= IDLE;
                alarm    <= 1'b0;
                tick_cnt <= '0;
              end else begin
                tick_cnt <= tick_cnt + 8'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: scoreboard bench for down_timer with a seconds-count reference model.
module tb_down_timer;

  localparam int unsigned MAXM = 59;
  localparam int unsigned DT   = 10;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] set_mt = '0, set_mu = '0, set_st = '0, set_su = '0;
  logic [3:0] mt, mu, st, su;
  logic       bw, running, alarm, zero;

  always #5 clk = ~clk;

  down_timer #(.MAX_MIN(MAXM), .DONE_TICKS(DT)) dut (
    .clk(clk), .res(res), .en(en), .load(load), .start(start), .stop(stop),
    .set_mt(set_mt), .set_mu(set_mu), .set_st(set_st), .set_su(set_su),
    .mt(mt), .mu(mu), .st(st), .su(su),
    .bw(bw), .running(running), .alarm(alarm), .zero(zero)
  );

  typedef struct {
    logic [15:0] digits;
    logic        running;
    logic        alarm;
    logic        zero;
    logic        bw;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: remaining time kept as a plain number of seconds.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mmode_t;
  mmode_t m_mode;
  int     m_secs, m_reload, m_ticks;
  bit     m_pulse;

  function automatic int clampi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic int preset_secs(input int a, input int b, input int c, input int d);
    int mins, secs;
    mins = clampi(a, 9) * 10 + clampi(b, 9);
    if (mins > int'(MAXM)) mins = MAXM;
    secs = clampi(c, 5) * 10 + clampi(d, 9);
    return mins * 60 + secs;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_secs = 0; m_reload = 0; m_ticks = 0; m_pulse = 0;
  endfunction

  function automatic void model_step(input bit e, input bit l, input bit s, input bit p,
                                     input int a, input int b, input int c, input int d);
    m_pulse = 0;
    case (m_mode)
      M_IDLE, M_PAUSE: begin
        if (l) begin
          m_secs = preset_secs(a, b, c, d); m_reload = m_secs;
        end else if (!p && s && m_secs != 0) m_mode = M_RUN;
      end
      M_ALARM: begin
        if (l) begin
          m_secs = preset_secs(a, b, c, d); m_reload = m_secs; m_mode = M_IDLE;
        end else if (p) m_mode = M_IDLE;
        else if (e) begin
          m_ticks++;
          if (m_ticks == int'(DT)) begin m_mode = M_IDLE; m_ticks = 0; end
        end
      end
      M_RUN: begin
        if (p) m_mode = M_PAUSE;
        else if (e) begin
          m_secs--;
          if (m_secs == 0) begin
`ifdef TIMER_AUTORELOAD_EN
            m_secs = m_reload; m_pulse = 1;
`else
            m_mode = M_ALARM; m_ticks = 0;
`endif
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  function automatic void push_exp(input string tag);
    exp_t x;
    x.digits  = {4'(m_secs / 600), 4'((m_secs / 60) % 10), 4'((m_secs % 60) / 10), 4'(m_secs % 10)};
    x.running = (m_mode == M_RUN);
    x.alarm   = (m_mode == M_ALARM) || m_pulse;
    x.zero    = (m_secs == 0);
    x.bw      = 1'b0;
    x.tag     = tag;
    q.push_back(x);
  endfunction

  // Monitor: one expectation per clk edge (or async reset edge) while any are queued.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or posedge res);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        total++;
        if ({mt, mu, st, su, running, alarm, zero, bw} !== {x.digits, x.running, x.alarm, x.zero, x.bw}) begin
          bad++;
          $display("FAIL %s: got %h%h:%h%h run=%b alarm=%b zero=%b bw=%b, expected %h:%h run=%b alarm=%b zero=%b bw=%b",
                   x.tag, mt, mu, st, su, running, alarm, zero, bw,
                   x.digits[15:8], x.digits[7:0], x.running, x.alarm, x.zero, x.bw);
        end
      end
    end
  end

  task automatic drive(input bit e, input bit l, input bit s, input bit p,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input string tag);
    @(negedge clk);
    res = 1'b0;
    en = e; load = l; start = s; stop = p;
    set_mt = a; set_mu = b; set_st = c; set_su = d;
    model_step(e, l, s, p, int'(a), int'(b), int'(c), int'(d));
    push_exp(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, tag);
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input string tag);
    drive(0, 1, 0, 0, a, b, c, d, tag);
  endtask

  task automatic do_start(input string tag);
    drive(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, tag);
  endtask

  task automatic do_stop(input string tag);
    drive(0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0, tag);
  endtask

  // Asynchronous reset raised mid-cycle; checked before the next clk edge.
  task automatic pulse_reset(input string tag);
    en = 0; load = 0; start = 0; stop = 0;
    model_reset();
    push_exp(tag);
    res = 1'b1;
    push_exp({tag, "_hold"});
  endtask

  initial begin
    bit e, l, s, p;
    logic [3:0] a, b, c, d;
    #1;
    pulse_reset("reset_init");

    // Reset while running at 01:23
    do_load(4'd0, 4'd1, 4'd2, 4'd3, "t1_load");
    do_start("t1_start");
    drive(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, "t1_run");
    @(negedge clk);
    #1;
    pulse_reset("t1_async");

    // Borrow across digits from 10:00
    do_load(4'd1, 4'd0, 4'd0, 4'd0, "t2_load");
    do_start("t2_start");
    ticks(1, "t2_0959");
    ticks(59, "t2_to0900");
    ticks(1, "t2_0859");
    do_stop("t2_stop");

    // Expiry and alarm duration (load in PAUSE stays paused)
    do_load(4'd0, 4'd0, 4'd0, 4'd2, "t3_load");
    do_start("t3_start");
    ticks(2, "t3_expire");
    ticks(int'(DT) + 2, "t3_alarm");

    // Clamping and start refused at 00:00
    do_load(4'd9, 4'hF, 4'd7, 4'hC, "t4_clamp");
    do_load(4'hA, 4'd3, 4'd6, 4'd4, "t4_clamp2");
    do_load(4'd0, 4'd0, 4'd0, 4'd0, "t4_zero");
    do_start("t4_start_zero");
    do_load(4'd9, 4'hF, 4'd7, 4'hC, "t4_clamp3");
    do_start("t4_start");
    ticks(1, "t4_tick");
    do_stop("t4_stop");

    // stop with en pauses without decrement
    do_load(4'd0, 4'd0, 4'd3, 4'd1, "t5_load");
    do_start("t5_start");
    ticks(1, "t5_0030");
    drive(1, 0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0, "t5_stop_en");
    ticks(5, "t5_paused");
    drive(1, 1, 0, 0, 4'd0, 4'd0, 4'd1, 4'd5, "t5_load_en");
    do_start("t5_resume");
    ticks(1, "t5_0014");
    drive(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd9, "t5_load_in_run");
    do_stop("t5_stop2");

    // Alarm silenced by stop and by load
    do_load(4'd0, 4'd0, 4'd0, 4'd1, "t7_load");
    drive(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, "t7_start");
    ticks(1, "t7_expire");
    drive(1, 0, 1, 1, 4'd0, 4'd0, 4'd0, 4'd0, "t7_stop");
    do_load(4'd0, 4'd0, 4'd0, 4'd1, "t7_load2");
    do_start("t7_start2");
    ticks(1, "t7_expire2");
    ticks(3, "t7_alarm");
    do_load(4'd0, 4'd0, 4'd0, 4'd5, "t7_load_alarm");

`ifdef TIMER_AUTORELOAD_EN
    // Auto-reload from 00:03
    do_load(4'd0, 4'd0, 4'd0, 4'd3, "t6_load");
    do_start("t6_start");
    ticks(7, "t6_reload");
    do_stop("t6_stop");
`endif

    // Randomized traffic, biased toward short presets so expiry is frequent
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom % 3) == 0;
      l = ($urandom % 20) == 0;
      s = ($urandom % 8) == 0;
      p = ($urandom % 16) == 0;
      if ($urandom % 2) begin
        a = 4'd0; b = 4'd0; c = 4'($urandom % 2); d = 4'($urandom_range(0, 15));
      end else begin
        a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15));
      end
      drive(e, l, s, p, a, b, c, d, "random");
    end

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
